// File: rtl/risc_encode_if.sv
// Handshake bundle for the instruction encoder: field-set input side,
// encoded-word output side and the illegal-opcode status.
//
// Both sides use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; a source holds its payload stable while
// valid is high and ready is low, and ready never depends on valid.
interface risc_encode_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [2:0]        in_opnda;
    logic [2:0]        in_opndb;
    logic [2:0]        in_dst;
    logic              out_valid;
    logic              out_ready;
    logic [12:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    // Producer of field sets / consumer of encoded words.
    modport master (
        output in_valid, in_opcode, in_opnda, in_opndb, in_dst, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_opcode, in_opnda, in_opndb, in_dst, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_cnt
    );
endinterface

// File: rtl/risc_encode.sv
// Instruction encoder for the 13-bit RISC datapath. Field sets are
// canonicalized per opcode class, packed as {opcode, opnda, opndb, dst},
// queued in a small FIFO and drained with an auto-incrementing memory
// write address. Opcode 14 is illegal: it is dropped and counted.
module risc_encode #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    risc_encode_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [3:0] OP_ILLEGAL = 4'd14;

    logic [12:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        illegal;
    logic        push;
    logic        pop;
    logic [12:0] word;

    // Ready/valid come from the registered count only, so a pop in the
    // same cycle never lets an extra word in.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign accept    = bus.in_valid && in_ready;
    assign illegal   = (bus.in_opcode == OP_ILLEGAL);
    assign push      = accept && !illegal;
    assign pop       = out_valid && bus.out_ready;

    // Canonicalize fields by opcode class and pack the instruction word.
    always_comb begin
        word = {bus.in_opcode, bus.in_opnda, bus.in_opndb, bus.in_dst};
        unique case (bus.in_opcode)
            4'd0:                          word[8:0] = 9'd0;  // nop
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5:  ;                  // binary
            4'd15:                         word[2:0] = 3'd0;  // st
            default:                       word[5:3] = 3'd0;  // unary (and illegal, never stored)
        endcase
    end

    // Next-state for pointers, occupancy, write address and error status.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wa_d      = pop  ? wa_q + 1'b1     : wa_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (accept && illegal) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hff) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Register state; reset flushes the FIFO and wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wa_q      <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 13'd0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wa_q      <= wa_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= word;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = mem_q[rd_ptr_q];
    assign bus.out_addr  = wa_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule
